// File: rtl/ex_div_pkg.sv
// Shared encodings and helpers for the execute-stage divider.
package ex_div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Two's-complement magnitude; 0x80000000 maps onto itself and is read as unsigned.
  function automatic logic [REG_BUS-1:0] magnitude(input logic [REG_BUS-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[REG_BUS-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle,
// returning {remainder, quotient} for the HI/LO write path.
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] divisor_q;
  logic        dividend_neg;
  logic        divisor_neg;
  logic        signed_q;

  logic [32:0] diff;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  assign diff      = {rem_q, quo_q[31]} - {1'b0, divisor_q};
  assign quo_final = (signed_q && (dividend_neg ^ divisor_neg)) ? (~quo_q + 32'd1) : quo_q;
  assign rem_final = (signed_q && dividend_neg) ? (~rem_q + 32'd1) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= 6'd0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      divisor_q    <= 32'd0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      signed_q     <= 1'b0;
      ready_o      <= DIV_RESULT_NOT_READY;
      result_o     <= 64'd0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= 64'd0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DIV_BYZERO;
            end else begin
              state        <= DIV_ON;
              cnt          <= 6'd0;
              rem_q        <= 32'd0;
              quo_q        <= magnitude(opdata1_i, signed_div_i);
              divisor_q    <= magnitude(opdata2_i, signed_div_i);
              dividend_neg <= signed_div_i & opdata1_i[31];
              divisor_neg  <= signed_div_i & opdata2_i[31];
              signed_q     <= signed_div_i;
            end
          end
        end
        DIV_BYZERO: begin
          state    <= DIV_END;
          ready_o  <= DIV_RESULT_READY;
          result_o <= 64'd0;
        end
        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            cnt      <= 6'd0;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= 64'd0;
          end else if (cnt != 6'd32) begin
            // A non-negative trial difference means the divisor fits: keep it and shift in a 1.
            if (!diff[32]) begin
              rem_q <= diff[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end else begin
              rem_q <= {rem_q[30:0], quo_q[31]};
              quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end else begin
            state    <= DIV_END;
            cnt      <= 6'd0;
            ready_o  <= DIV_RESULT_READY;
            result_o <= {rem_final, quo_final};
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= 64'd0;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
